// File: rtl/period_stepper.sv
// Button-driven period stepper: single steps on a tap, then auto-repeat while held.
// Feeds a saturating half-period count to a downstream variable clock divider.
module period_stepper #(
    parameter logic [31:0] INIT_PERIOD   = 32'd8,
    parameter logic [31:0] MIN_PERIOD    = 32'd4,
    parameter logic [31:0] MAX_PERIOD    = 32'd20,
    parameter logic [31:0] STEP          = 32'd4,
    parameter logic [31:0] HOLD_CYCLES   = 32'd10,
    parameter logic [31:0] REPEAT_CYCLES = 32'd3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_up,
    input  logic        btn_dn,
    output logic [31:0] period,
    output logic        period_upd,
    output logic        at_min,
    output logic        at_max
);

    typedef enum logic [1:0] {IDLE, PRESS, REPEAT} state_t;

    state_t      state, state_nxt;
    logic [31:0] cnt, cnt_nxt;
    logic        dir, dir_nxt;      // 1 = up
    logic        press_up, press_dn, held, step;
    logic [32:0] up_sum, dn_floor;
    logic [31:0] period_up, period_dn, period_nxt;

    assign press_up = btn_up & ~btn_dn;
    assign press_dn = btn_dn & ~btn_up;
    assign held     = dir ? press_up : press_dn;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dir_nxt   = dir;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (press_up | press_dn) begin
                    step      = 1'b1;
                    dir_nxt   = press_up;
                    cnt_nxt   = '0;
                    state_nxt = PRESS;
                end
            end
            PRESS: begin
                if (!held) begin
                    state_nxt = IDLE;
                end else if (cnt == HOLD_CYCLES - 32'd1) begin
                    step      = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = REPEAT;
                end else begin
                    cnt_nxt   = cnt + 32'd1;
                end
            end
            REPEAT: begin
                if (!held) begin
                    state_nxt = IDLE;
                end else if (cnt == REPEAT_CYCLES - 32'd1) begin
                    step      = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + 32'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // 33-bit compares keep the saturation tests free of wrap-around
    assign up_sum    = {1'b0, period} + {1'b0, STEP};
    assign dn_floor  = {1'b0, MIN_PERIOD} + {1'b0, STEP};
    assign period_up = (up_sum > {1'b0, MAX_PERIOD}) ? MAX_PERIOD : up_sum[31:0];
    assign period_dn = ({1'b0, period} < dn_floor) ? MIN_PERIOD : period - STEP;

    always_comb begin
        period_nxt = period;
        if (step)
            period_nxt = dir_nxt ? period_up : period_dn;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            dir        <= 1'b0;
            period     <= INIT_PERIOD;
            period_upd <= 1'b0;
            at_min     <= (INIT_PERIOD == MIN_PERIOD);
            at_max     <= (INIT_PERIOD == MAX_PERIOD);
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            dir        <= dir_nxt;
            period     <= period_nxt;
            period_upd <= (period_nxt != period);
            at_min     <= (period_nxt == MIN_PERIOD);
            at_max     <= (period_nxt == MAX_PERIOD);
        end
    end

endmodule

// File: tb/tb_period_stepper.sv
// Scoreboard bench for period_stepper: stimulus queues expected updates with their
// edge index, a monitor pops them whenever period_upd fires.
module tb_period_stepper;

    logic        clk;
    logic        rst_n;
    logic        btn_up, btn_dn;
    logic [31:0] period;
    logic        period_upd, at_min, at_max;

    typedef struct {
        int          cyc;
        logic [31:0] per;
        logic        mn;
        logic        mx;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    period_stepper dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_up     (btn_up),
        .btn_dn     (btn_dn),
        .period     (period),
        .period_upd (period_upd),
        .at_min     (at_min),
        .at_max     (at_max)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (edge %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [31:0] p, input logic mn, input logic mx);
        exp_t e;
        e.cyc = c; e.per = p; e.mn = mn; e.mx = mx;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        chk("async_rst_period", period, 32'd8);
        chk("async_rst_upd", {31'd0, period_upd}, 32'd0);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: every update pulse must match the head of the queue at its exact edge
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            total++; bad++;
            $display("FAIL missed_update: no pulse observed, want period=%0d at edge %0d", e.per, e.cyc);
        end
        if (period_upd) begin
            if (q.size() == 0 || q[0].cyc != cyc) begin
                total++; bad++;
                $display("FAIL unexpected_update: got period=%0d at edge %0d, want no pulse", period, cyc);
            end else begin
                e = q.pop_front();
                chk("upd_period", period, e.per);
                chk("upd_at_min", {31'd0, at_min}, {31'd0, e.mn});
                chk("upd_at_max", {31'd0, at_max}, {31'd0, e.mx});
            end
        end
    end

    initial begin
        int c;
        btn_up = 1'b0;
        btn_dn = 1'b0;
        rst_n  = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_period", period, 32'd8);
        chk("rst_upd", {31'd0, period_upd}, 32'd0);
        chk("rst_at_min", {31'd0, at_min}, 32'd0);
        chk("rst_at_max", {31'd0, at_max}, 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // tap up for 3 cycles: one step to 12
        c = cyc; btn_up = 1'b1; push(c + 1, 32'd12, 1'b0, 1'b0);
        tick(3); btn_up = 1'b0; tick(3);
        chk("tap_period", period, 32'd12);

        // hold up 20 cycles from 8: edges +1, +11, +14, then saturated
        pulse_reset(); tick(1);
        c = cyc; btn_up = 1'b1;
        push(c + 1, 32'd12, 1'b0, 1'b0);
        push(c + 11, 32'd16, 1'b0, 1'b0);
        push(c + 14, 32'd20, 1'b0, 1'b1);
        tick(20); btn_up = 1'b0; tick(2);
        chk("hold_period", period, 32'd20);
        chk("hold_at_max", {31'd0, at_max}, 32'd1);

        // down to min, then a saturated tap that must not pulse
        pulse_reset(); tick(1);
        c = cyc; btn_dn = 1'b1; push(c + 1, 32'd4, 1'b1, 1'b0);
        tick(2); btn_dn = 1'b0; tick(2);
        btn_dn = 1'b1; tick(2); btn_dn = 1'b0; tick(2);
        chk("min_period", period, 32'd4);
        chk("min_at_min", {31'd0, at_min}, 32'd1);

        // both high from IDLE: nothing
        pulse_reset(); tick(1);
        btn_up = 1'b1; btn_dn = 1'b1; tick(3);
        chk("both_period", period, 32'd8);
        btn_up = 1'b0; btn_dn = 1'b0; tick(1);
        // up hold interrupted by dn, then release up -> one down step
        c = cyc; btn_up = 1'b1; push(c + 1, 32'd12, 1'b0, 1'b0);
        tick(5); btn_dn = 1'b1; tick(12);
        c = cyc; btn_up = 1'b0; push(c + 1, 32'd8, 1'b0, 1'b0);
        tick(2); btn_dn = 1'b0; tick(2);
        chk("simul_period", period, 32'd8);

        // direct switch up -> dn: dn step lands two edges later
        c = cyc; btn_up = 1'b1; push(c + 1, 32'd12, 1'b0, 1'b0);
        tick(3);
        c = cyc; btn_up = 1'b0; btn_dn = 1'b1; push(c + 2, 32'd8, 1'b0, 1'b0);
        tick(3); btn_dn = 1'b0; tick(2);
        chk("switch_period", period, 32'd8);

        // reset during REPEAT at 16 with up still held -> 8, then 12 on first edge
        c = cyc; btn_up = 1'b1;
        push(c + 1, 32'd12, 1'b0, 1'b0);
        push(c + 11, 32'd16, 1'b0, 1'b0);
        tick(12);
        chk("pre_rst_period", period, 32'd16);
        c = cyc; push(c + 1, 32'd12, 1'b0, 1'b0);
        pulse_reset();
        tick(2); btn_up = 1'b0; tick(3);
        chk("post_rst_period", period, 32'd12);

        tick(2);
        chk("queue_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
